bcd_conv_scheduler: RTL

//  Shares one binary-to-BCD converter between NUM_CH value sources (e.g. operand, cube-root result, status).

---
 rtl/display_pkg.sv | 12 +
 rtl/bcd_conv_scheduler_rr_arbiter.sv | 30 +++
 rtl/bcd_conv_scheduler.sv | 103 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared state type, blank-digit code and width helper
// for the BCD conversion scheduler.
package display_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} sched_state_t;
    localparam logic [3:0] DIGIT_BLANK = 4'hA;
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or
// above ptr, wrapping past the top channel.
module rr_arbiter
    import display_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int PTR_W = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [PTR_W-1:0]  idx,
    output logic              found
);
    logic [PTR_W-1:0] k;
    always_comb begin
        idx = '0;
        found = 1'b0;
        k = '0;
        // walk offsets downward so the request nearest to ptr is assigned last
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            k = PTR_W'((int'(ptr) + i) % NUM_CH);
            if (req[k]) begin
                idx = k;
                found = 1'b1;
            end
        end
        grant = found ? NUM_CH'(1) << idx : '0;
    end
endmodule

// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: shares one binary-to-BCD converter between channels,
// keeps a result buffer per channel and drives the selected one to the display.
module bcd_conv_scheduler
    import display_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int BIN_W       = 32,
    parameter int BCD_W       = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH*BIN_W-1:0]   value,
    output logic [NUM_CH-1:0]         ack,
    output logic                      ack_err,
    output logic                      conv_start,
    output logic [BIN_W-1:0]          conv_binary,
    input  logic                      conv_dv,
    input  logic [BCD_W-1:0]          conv_bcd,
    input  logic [clog2(NUM_CH):0]    disp_sel,
    output logic [BCD_W-1:0]          disp_bcd,
    output logic                      disp_valid,
    output logic                      busy
);
    localparam int PTR_W = clog2(NUM_CH);
    localparam int TMO_W = clog2(TIMEOUT_CYC);

    sched_state_t state, next_state;
    logic [PTR_W-1:0]  rr_ptr, g, arb_idx;
    logic [NUM_CH-1:0] arb_grant, g_oh, valid_q;
    logic              arb_found, tmo_hit, sel_ok;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [BCD_W-1:0]  bufs [NUM_CH];

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .found (arb_found)
    );

    assign tmo_hit = tmo_cnt == TMO_W'(TIMEOUT_CYC - 1);
    assign busy    = state != IDLE;
    // disp_sel carries one spare bit so out-of-range selects are expressible
    assign sel_ok  = disp_sel < ($bits(disp_sel))'(NUM_CH);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = arb_found ? ISSUE : IDLE;
            ISSUE:   next_state = WAIT;
            WAIT:    next_state = (conv_dv || tmo_hit) ? DONE : WAIT;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            g           <= '0;
            g_oh        <= '0;
            valid_q     <= '0;
            tmo_cnt     <= '0;
            ack         <= '0;
            ack_err     <= 1'b0;
            conv_start  <= 1'b0;
            conv_binary <= '0;
            disp_bcd    <= '0;
            disp_valid  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) bufs[i] <= '0;
        end else begin
            state      <= next_state;
            conv_start <= state == IDLE && arb_found;
            ack        <= '0;
            ack_err    <= 1'b0;
            if (state == IDLE && arb_found) begin
                g           <= arb_idx;
                g_oh        <= arb_grant;
                conv_binary <= value[arb_idx*BIN_W +: BIN_W];
            end
            if (state == ISSUE) tmo_cnt <= '0;
            // results land in the buffer on DONE entry so the display sees them right after DONE
            if (state == WAIT) begin
                if (conv_dv) begin
                    bufs[g]    <= conv_bcd;
                    valid_q[g] <= 1'b1;
                    ack        <= g_oh;
                end else if (tmo_hit) begin
                    ack     <= g_oh;
                    ack_err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
            if (state == DONE) rr_ptr <= (g == PTR_W'(NUM_CH - 1)) ? '0 : g + 1'b1;
            disp_bcd   <= sel_ok ? bufs[disp_sel[PTR_W-1:0]] : '0;
            disp_valid <= sel_ok && valid_q[disp_sel[PTR_W-1:0]];
        end
    end
endmodule
